uart_rx_fifo_ctrl: RTL and testbench

Standalone UART receiver that pairs with the team's UART transmitter. It recovers frames of start + 8 data (LSB first) + optional even parity + 2 stop bits from an asynchronous RX line. It uses 16x oversampling with 3-sample majority voting, detects parity, framing and break errors, and buffers frames in a FIFO. Received frames are handed to the consumer over a valid/ready interface, with a sticky overrun flag.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_sync_fifo.sv | 86 ++++++++
 rtl/uart_rx_fifo_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t      : receiver FSM states
//   uart_rx_entry_t : one received frame as stored in the receive FIFO
//   OVERSAMPLE      : oversample ticks per bit
//   SAMPLE_LO/MID/HI: oversample counts at which the three bit votes are taken
//   majority3       : 2-of-3 vote helper
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;
    localparam logic [3:0] BIT_END    = 4'd15;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP1  = 3'd4,
        RX_STOP2  = 3'd5
    } rx_state_t;

    // brk stands for the break condition ("break" is a reserved word)
    typedef struct packed {
        logic       brk;
        logic       perr;
        logic       ferr;
        logic       parity;
        logic [7:0] data;
    } uart_rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO, DEPTH entries of WIDTH bits (DEPTH a power of 2).
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request; accepted when not full, or when full
//                     and a pop happens in the same cycle
//   pop, pop_data   : read request (ignored when empty); pop_data shows the
//                     head entry, or the last popped entry while empty
//   count           : number of stored entries (0..DEPTH)
//   full, empty     : status flags
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] last_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == (AW+1)'(0));
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign count = count_r;

    // Qualify requests: a full FIFO still accepts a push if the head leaves this cycle
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Read mux: while empty, keep presenting the most recently popped entry
    always_comb begin
        if (empty) begin
            pop_data = last_r;
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

    // Storage array; contents need no reset because reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and last-popped copy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
            last_r   <= WIDTH'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                last_r   <= mem_r[rd_ptr_r];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
// UART receiver: start + 8 data bits (LSB first) + optional even parity +
// 2 stop bits, 16x oversampling with 2-of-3 voting, frames buffered in a FIFO.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   RX             : asynchronous serial input, idle high
//   rx_data        : head entry {parity bit, data[7:0]}
//   rx_frame_err   : head entry had a stop bit sampled low
//   rx_parity_err  : head entry parity mismatch (even parity)
//   rx_break       : head entry is a break (all zero, stop1 low)
//   rx_valid       : FIFO holds at least one entry
//   rx_ready       : consumer pops the head when rx_valid is high
//   fifo_count     : number of stored entries
//   overrun        : sticky, a frame was dropped on a full FIFO
//   overrun_clr    : clears overrun (a simultaneous new overrun wins)
//   rx_busy        : receiver FSM is inside a frame
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int PARITY_EN    = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX,
    output logic [8:0]                    rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          rx_busy
);

    import uart_pkg::*;

    localparam int OSR_DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int OSR_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;

    logic [OSR_W-1:0] osr_cnt_r;
    logic             os_tick_s;
    logic             sync1_r;
    logic             rxs_r;
    logic             rxs_d_r;
    logic             start_edge_s;
    rx_state_t        state_r;
    logic [3:0]       os_cnt_r;
    logic [2:0]       bit_idx_r;
    logic             s_lo_r;
    logic             s_mid_r;
    logic             bit_maj_s;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic             stop1_low_r;
    logic             busy_r;
    uart_rx_entry_t   next_entry_s;
    uart_rx_entry_t   entry_r;
    logic             push_r;
    logic             overrun_r;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    uart_rx_entry_t   head_s;

    assign os_tick_s    = (osr_cnt_r == OSR_W'(OSR_DIV - 1));
    assign start_edge_s = (state_r == RX_IDLE) & rxs_d_r & ~rxs_r;
    // the third vote is the live synchronized sample at SAMPLE_HI
    assign bit_maj_s    = majority3(s_lo_r, s_mid_r, rxs_r);
    assign pop_s        = ~fifo_empty_s & rx_ready;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync1_r <= RX;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
        end
    end

    // Oversample prescaler; realigned to the start edge so samples sit mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_cnt_r <= OSR_W'(0);
        end else if (start_edge_s || os_tick_s) begin
            osr_cnt_r <= OSR_W'(0);
        end else begin
            osr_cnt_r <= osr_cnt_r + OSR_W'(1);
        end
    end

    // Frame entry assembled from the bits collected so far and the stop2 vote
    always_comb begin
        next_entry_s.data = shift_r;
        next_entry_s.ferr = stop1_low_r | ~bit_maj_s;
        if (PARITY_EN != 0) begin
            next_entry_s.parity = parity_r;
            next_entry_s.perr   = (^shift_r) ^ parity_r;
            next_entry_s.brk    = (shift_r == 8'd0) & ~parity_r & stop1_low_r;
        end else begin
            next_entry_s.parity = 1'b0;
            next_entry_s.perr   = 1'b0;
            next_entry_s.brk    = (shift_r == 8'd0) & stop1_low_r;
        end
    end

    // Receiver FSM: bit timing, voting, shifting and the registered push request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RX_IDLE;
            os_cnt_r    <= 4'd0;
            bit_idx_r   <= 3'd0;
            s_lo_r      <= 1'b1;
            s_mid_r     <= 1'b1;
            shift_r     <= 8'd0;
            parity_r    <= 1'b0;
            stop1_low_r <= 1'b0;
            busy_r      <= 1'b0;
            entry_r     <= uart_rx_entry_t'(12'd0);
            push_r      <= 1'b0;
        end else begin
            push_r <= 1'b0;
            if (state_r == RX_IDLE) begin
                if (start_edge_s) begin
                    state_r     <= RX_START;
                    os_cnt_r    <= 4'd0;
                    bit_idx_r   <= 3'd0;
                    stop1_low_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
            end else if (os_tick_s) begin
                os_cnt_r <= os_cnt_r + 4'd1;
                if (os_cnt_r == SAMPLE_LO) begin
                    s_lo_r <= rxs_r;
                end
                if (os_cnt_r == SAMPLE_MID) begin
                    s_mid_r <= rxs_r;
                end
                case (state_r)
                    RX_START: begin
                        if (os_cnt_r == SAMPLE_HI && bit_maj_s) begin
                            // line back high mid-bit: glitch, not a start bit
                            state_r <= RX_IDLE;
                            busy_r  <= 1'b0;
                        end else if (os_cnt_r == BIT_END) begin
                            state_r <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (os_cnt_r == SAMPLE_HI) begin
                            shift_r <= {bit_maj_s, shift_r[7:1]};
                        end else if (os_cnt_r == BIT_END) begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            if (bit_idx_r == 3'd7) begin
                                state_r <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (os_cnt_r == SAMPLE_HI) begin
                            parity_r <= bit_maj_s;
                        end else if (os_cnt_r == BIT_END) begin
                            state_r <= RX_STOP1;
                        end
                    end
                    RX_STOP1: begin
                        if (os_cnt_r == SAMPLE_HI) begin
                            stop1_low_r <= ~bit_maj_s;
                        end else if (os_cnt_r == BIT_END) begin
                            state_r <= RX_STOP2;
                        end
                    end
                    RX_STOP2: begin
                        // leave mid-bit so a back-to-back start edge is not missed
                        if (os_cnt_r == SAMPLE_HI) begin
                            entry_r <= next_entry_s;
                            push_r  <= 1'b1;
                            state_r <= RX_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= RX_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky overrun: a push into a full FIFO with no pop that cycle is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (push_r && fifo_full_s && !pop_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    uart_sync_fifo #(
        .WIDTH ($bits(uart_rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_r),
        .push_data (entry_r),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign rx_data       = {head_s.parity, head_s.data};
    assign rx_frame_err  = head_s.ferr;
    assign rx_parity_err = head_s.perr;
    assign rx_break      = head_s.brk;
    assign rx_valid      = ~fifo_empty_s;
    assign overrun       = overrun_r;
    assign rx_busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
// Self-checking bench: table of hand-computed frames, randomized frames
// against a frame-level reference model with an expected-entry queue, and
// directed sequences for glitch, break, overrun, full push/pop and reset.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;

    localparam int SYS_CLK_FREQ = 3_200_000;
    localparam int BAUD_RATE    = 100_000;
    localparam int PARITY_EN    = 1;
    localparam int FIFO_DEPTH   = 8;
    localparam int BIT_CLKS     = SYS_CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rx_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [8:0] rx_data;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_break;
    logic       rx_valid;
    logic [3:0] fifo_count;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       s1;
        logic       s2;
        logic [8:0] e_data;
        logic       e_ferr;
        logic       e_perr;
        logic       e_brk;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo_ctrl #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .PARITY_EN    (PARITY_EN),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RX            (RX),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_break      (rx_break),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .fifo_count    (fifo_count),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what the receiver should report for a frame with these line bits
    function automatic logic [11:0] model(input logic [7:0] d, input logic p,
                                          input logic s1, input logic s2);
        logic perr;
        logic ferr;
        logic brk;
        perr = ((^d) != p);
        ferr = !s1 || !s2;
        brk  = (d == 8'd0) && !p && !s1;
        return {brk, perr, ferr, p, d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        RX = 1'b0;
        step(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            step(BIT_CLKS);
        end
        if (PARITY_EN != 0) begin
            RX = p;
            step(BIT_CLKS);
        end
        RX = s1;
        step(BIT_CLKS);
        RX = s2;
        step(BIT_CLKS);
        RX = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_rx_busy"}, rx_busy, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_flags"}, {rx_break, rx_parity_err, rx_frame_err}, 0);
    endtask

    // Consumer-side scoreboard: every accepted head entry must match the model queue
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %0h expected no entry",
                         {rx_break, rx_parity_err, rx_frame_err, rx_data});
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({rx_break, rx_parity_err, rx_frame_err, rx_data} !== e) begin
                    failures++;
                    $display("FAIL pop_entry: got %0h expected %0h",
                             {rx_break, rx_parity_err, rx_frame_err, rx_data}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int busy_seen;
        int idle_at;
        logic [7:0] d;
        logic p;
        logic s1;
        logic s2;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b1, 9'h007, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 9'h181, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 9'h100, 1'b1, 1'b1, 1'b0};

        // reset state
        step(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(5);

        // table-driven frames, consumer always ready
        rx_ready = 1'b1;
        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].e_brk, vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_data});
            send_frame(vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2);
            step(20);
            check("vec_fifo_empty", fifo_count, 0);
            check("vec_held_data", rx_data, vecs[i].e_data);
            check("vec_held_flags", {rx_break, rx_parity_err, rx_frame_err},
                  {vecs[i].e_brk, vecs[i].e_perr, vecs[i].e_ferr});
        end
        check("table_all_received", exp_q.size(), 0);

        // line held low well past a frame: exactly one break frame, then silence
        exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
        RX = 1'b0;
        step(BIT_CLKS * 20);
        check("break_idle_while_low", rx_busy, 0);
        RX = 1'b1;
        step(60);
        check("break_one_frame", exp_q.size(), 0);
        check("break_fifo_empty", fifo_count, 0);

        // 12-clock glitch: false start, receiver back to idle within a bit time
        busy_seen = 0;
        idle_at = -1;
        RX = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 12) RX = 1'b1;
            if (rx_busy) busy_seen = 1;
            else if (busy_seen != 0 && idle_at < 0) idle_at = c;
            step(1);
        end
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_idle_before_32", (idle_at >= 0 && idle_at < 32), 1);
        step(300);
        check("glitch_no_push", fifo_count, 0);

        // randomized frames against the reference model
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom_range(0, 255));
            p  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s1 = ($urandom_range(0, 5) != 0);
            s2 = ($urandom_range(0, 5) != 0);
            exp_q.push_back(model(d, p, s1, s2));
            send_frame(d, p, s1, s2);
            n = s2 ? $urandom_range(0, 20) : $urandom_range(4, 20);
            if (n > 0) step(n);
        end
        step(60);
        check("random_all_received", exp_q.size(), 0);

        // overrun: 9 back-to-back frames into a stalled FIFO
        rx_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            d = 8'(k);
            if (k <= 8) exp_q.push_back(model(d, ^d, 1'b1, 1'b1));
            send_frame(d, ^d, 1'b1, 1'b1);
        end
        check("ovr_count_full", fifo_count, 8);
        check("ovr_flag_set", overrun, 1);
        check("ovr_valid", rx_valid, 1);
        rx_ready = 1'b1;
        n = 0;
        while (fifo_count != 0 && n < 50) begin
            step(1);
            n++;
        end
        check("ovr_drained", fifo_count, 0);
        check("ovr_order", exp_q.size(), 0);
        check("ovr_sticky", overrun, 1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);

        // full FIFO: push lands on the same clock as a single pop
        rx_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            d = 8'(8'h11 + k);
            exp_q.push_back(model(d, ^d, 1'b1, 1'b1));
        end
        for (int k = 0; k < 8; k++) begin
            d = 8'(8'h11 + k);
            send_frame(d, ^d, 1'b1, 1'b1);
        end
        check("pp_full_before", fifo_count, 8);
        fork
            send_frame(8'h19, ^(8'h19), 1'b1, 1'b1);
            begin
                n = 0;
                while (!rx_busy && n < 64) begin
                    step(1);
                    n++;
                end
                n = 0;
                while (rx_busy && n < 400) begin
                    step(1);
                    n++;
                end
                // the FSM just left STOP2; the push happens on the next edge
                rx_ready = 1'b1;
                step(1);
                rx_ready = 1'b0;
            end
        join
        check("pp_count_same", fifo_count, 8);
        check("pp_no_overrun", overrun, 0);
        rx_ready = 1'b1;
        n = 0;
        while (fifo_count != 0 && n < 50) begin
            step(1);
            n++;
        end
        check("pp_order", exp_q.size(), 0);

        // reset mid-frame with an entry already buffered
        rx_ready = 1'b0;
        exp_q.push_back(model(8'h77, ^(8'h77), 1'b1, 1'b1));
        send_frame(8'h77, ^(8'h77), 1'b1, 1'b1);
        step(10);
        RX = 1'b0;
        step(BIT_CLKS);
        RX = 1'b0;
        step(BIT_CLKS);
        RX = 1'b0;
        step(BIT_CLKS);
        RX = 1'b1;
        step(BIT_CLKS / 2);
        check("mid_busy_before_reset", rx_busy, 1);
        check("mid_valid_before_reset", rx_valid, 1);
        rst_n = 1'b0;
        step(2);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        exp_q.delete();
        step(100);
        check("post_reset_idle", rx_busy, 0);
        rx_ready = 1'b1;
        exp_q.push_back(model(8'h5A, ^(8'h5A), 1'b1, 1'b1));
        send_frame(8'h5A, ^(8'h5A), 1'b1, 1'b1);
        step(40);
        check("post_reset_only_5a", exp_q.size(), 0);
        check("post_reset_data", rx_data, 9'h05A);
        check("post_reset_empty", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
